// File: rtl/sync_chain.sv
// Multi-flop level synchronizer: WIDTH independent bits, each passed through
// STAGES flops clocked by clk. There is no logic between the flops.
module sync_chain #(
  parameter int                 WIDTH     = 1,
  parameter int                 STAGES    = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_chain: STAGES must be in 2..4");
  end

  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [STAGES-1:0][WIDTH-1:0] s_q;
  logic [STAGES-1:0][WIDTH-1:0] s_d;

  always_comb begin
    s_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      s_d[i] = s_q[i-1];
    end
  end

  // NOTE: every synchronizer flop takes a reset value so q is defined from
  // the first cycle; <= keeps each stage reading the previous stage's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        s_q[i] <= RESET_VAL;
      end
    end else begin
      s_q <= s_d;
    end
  end

  assign q = s_q[STAGES-1];

endmodule

// File: rtl/sync_edge_cdc.sv
// Level synchronizer with single-cycle rising/falling edge strobes.
// Optional macro SYNC_EDGE_ANY_EN adds output ae = pe | ne.
module sync_edge_cdc #(
  parameter int                 WIDTH     = 1,
  parameter int                 STAGES    = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] pe,
  output logic [WIDTH-1:0] ne
`ifdef SYNC_EDGE_ANY_EN
  ,
  output logic [WIDTH-1:0] ae
`endif
);

  logic [WIDTH-1:0] q_hist_q;
  logic [WIDTH-1:0] q_hist_d;

  sync_chain #(
    .WIDTH     (WIDTH),
    .STAGES    (STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_chain (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

  always_comb begin
    q_hist_d = q;
  end

  // History resets to the same value as the chain, so reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_hist_q <= RESET_VAL;
    end else begin
      q_hist_q <= q_hist_d;
    end
  end

  assign pe = q & ~q_hist_q;
  assign ne = ~q & q_hist_q;

`ifdef SYNC_EDGE_ANY_EN
  assign ae = pe | ne;
`else
  // Without the any-edge output, pe and ne alone carry the edge information.
`endif

endmodule

// File: tb/tb_sync_edge_cdc.sv
// Self-checking bench for sync_edge_cdc: three configurations driven from one
// stimulus vector, checked against an edge-log model plus literal expectations.
module tb_sync_edge_cdc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d   = 4'b0000;

  // a: WIDTH=4 STAGES=2 RV=0000   (lanes 3:0)
  // b: WIDTH=1 STAGES=3 RV=1      (lane 0)
  // c: WIDTH=2 STAGES=4 RV=10     (lanes 3:2)
  logic [3:0] q_a, pe_a, ne_a;
  logic       q_b, pe_b, ne_b;
  logic [1:0] q_c, pe_c, ne_c;
`ifdef SYNC_EDGE_ANY_EN
  logic [3:0] ae_a;
  logic       ae_b;
  logic [1:0] ae_c;
`endif

  always #5 clk = ~clk;

  sync_edge_cdc #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'b0000)) dut_a (
    .clk(clk), .rst(rst), .d(d), .q(q_a), .pe(pe_a), .ne(ne_a)
`ifdef SYNC_EDGE_ANY_EN
    , .ae(ae_a)
`endif
  );

  sync_edge_cdc #(.WIDTH(1), .STAGES(3), .RESET_VAL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .d(d[0]), .q(q_b), .pe(pe_b), .ne(ne_b)
`ifdef SYNC_EDGE_ANY_EN
    , .ae(ae_b)
`endif
  );

  sync_edge_cdc #(.WIDTH(2), .STAGES(4), .RESET_VAL(2'b10)) dut_c (
    .clk(clk), .rst(rst), .d(d[3:2]), .q(q_c), .pe(pe_c), .ne(ne_c)
`ifdef SYNC_EDGE_ANY_EN
    , .ae(ae_c)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Log of what every clock edge saw on the inputs.
  int         edge_n = 0;
  logic [3:0] d_log   [0:1023];
  logic       rst_log [0:1023];

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    d_log[edge_n]   = d;
    rst_log[edge_n] = rst;
  end

  // q after edge n is d seen at edge n-s+1, unless a reset edge falls
  // anywhere in the window [n-s+1, n], in which case it is the reset value.
  function automatic logic [3:0] m_q(input int n, input int s, input logic [3:0] rv);
    for (int k = n - s + 1; k <= n; k++) begin
      if (k < 1 || rst_log[k]) return rv;
    end
    return d_log[n - s + 1];
  endfunction

  // Previous-cycle q as seen by the edge detector; a reset edge clears it.
  function automatic logic [3:0] m_qd(input int n, input int s, input logic [3:0] rv);
    if (n < 1 || rst_log[n]) return rv;
    return m_q(n - 1, s, rv);
  endfunction

  // Model comparison on every falling edge.
  always @(negedge clk) begin
    if (edge_n >= 1) begin
      logic [3:0] eq, eqd;
      eq  = m_q (edge_n, 2, 4'b0000);
      eqd = m_qd(edge_n, 2, 4'b0000);
      check("model.a.q",  q_a,  eq);
      check("model.a.pe", pe_a, eq & ~eqd);
      check("model.a.ne", ne_a, ~eq & eqd);
`ifdef SYNC_EDGE_ANY_EN
      check("model.a.ae", ae_a, eq ^ eqd);
`endif
      eq  = m_q (edge_n, 3, 4'b0001) & 4'b0001;
      eqd = m_qd(edge_n, 3, 4'b0001) & 4'b0001;
      check("model.b.q",  {3'b000, q_b},  eq);
      check("model.b.pe", {3'b000, pe_b}, eq & ~eqd);
      check("model.b.ne", {3'b000, ne_b}, ~eq & eqd);
`ifdef SYNC_EDGE_ANY_EN
      check("model.b.ae", {3'b000, ae_b}, eq ^ eqd);
`endif
      eq  = m_q (edge_n, 4, 4'b1000) & 4'b1100;
      eqd = m_qd(edge_n, 4, 4'b1000) & 4'b1100;
      check("model.c.q",  {q_c,  2'b00}, eq);
      check("model.c.pe", {pe_c, 2'b00}, eq & ~eqd & 4'b1100);
      check("model.c.ne", {ne_c, 2'b00}, ~eq & eqd & 4'b1100);
`ifdef SYNC_EDGE_ANY_EN
      check("model.c.ae", {ae_c, 2'b00}, (eq ^ eqd) & 4'b1100);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held 3 cycles with d[0]=1.
    rst = 1'b1;
    d   = 4'b0001;
    repeat (3) begin
      tick();
      check("rst.q_a",  q_a,  4'b0000);
      check("rst.pe_a", pe_a, 4'b0000);
      check("rst.ne_a", ne_a, 4'b0000);
      check("rst.q_b",  {3'b000, q_b}, 4'b0001);
      check("rst.q_c",  {2'b00, q_c},  4'b0010);
    end
    rst = 1'b0;
    tick();
    check("rel1.q_a",  q_a,  4'b0000);
    check("rel1.pe_a", pe_a, 4'b0000);
    tick();
    check("rel2.q_a",  q_a,  4'b0001);
    check("rel2.pe_a", pe_a, 4'b0001);
    tick();
    check("rel3.q_a",  q_a,  4'b0001);
    check("rel3.pe_a", pe_a, 4'b0000);
    repeat (4) tick();

    // Rising step on lane 1.
    d = 4'b0011;
    tick();
    check("rise1.q_a",  q_a,  4'b0001);
    check("rise1.pe_a", pe_a, 4'b0000);
    tick();
    check("rise2.q_a",  q_a,  4'b0011);
    check("rise2.pe_a", pe_a, 4'b0010);
    check("rise2.ne_a", ne_a, 4'b0000);
    tick();
    check("rise3.pe_a", pe_a, 4'b0000);
    repeat (3) tick();

    // Falling step on lane 0, watched on the 3-stage instance.
    d = 4'b0010;
    tick();
    check("fall1.q_b",  {3'b000, q_b},  4'b0001);
    check("fall1.ne_b", {3'b000, ne_b}, 4'b0000);
    tick();
    check("fall2.q_b",  {3'b000, q_b},  4'b0001);
    tick();
    check("fall3.q_b",  {3'b000, q_b},  4'b0000);
    check("fall3.ne_b", {3'b000, ne_b}, 4'b0001);
    check("fall3.pe_b", {3'b000, pe_b}, 4'b0000);
    tick();
    check("fall4.ne_b", {3'b000, ne_b}, 4'b0000);

    // Toggle lane 0 every cycle for 8 cycles.
    for (int i = 0; i < 8; i++) begin
      d[0] = ~d[0];
      tick();
    end
    d = 4'b0000;
    repeat (5) tick();

    // Edge in flight when reset arrives: it must never produce a strobe.
    d = 4'b0001;
    tick();
    rst = 1'b1;
    d   = 4'b0000;
    tick();
    check("midrst1.q_a",  q_a,  4'b0000);
    check("midrst1.pe_a", pe_a, 4'b0000);
    tick();
    check("midrst2.q_a",  q_a,  4'b0000);
    check("midrst2.pe_a", pe_a, 4'b0000);
    rst = 1'b0;
    repeat (4) begin
      tick();
      check("midrst.post.pe_a", pe_a, 4'b0000);
    end

    // Independent lanes: 0101 -> 0110.
    d = 4'b0101;
    repeat (4) tick();
    d = 4'b0110;
    tick();
    check("width1.pe_a", pe_a, 4'b0000);
    check("width1.ne_a", ne_a, 4'b0000);
    tick();
    check("width2.q_a",  q_a,  4'b0110);
    check("width2.pe_a", pe_a, 4'b0010);
    check("width2.ne_a", ne_a, 4'b0001);
    tick();
    check("width3.pe_a", pe_a, 4'b0000);
    check("width3.ne_a", ne_a, 4'b0000);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
